// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor built around one
// full-add cell. Operands are captured on a start handshake. Bits are processed
// LSB first, one per clock. The result, carry and overflow flags are published
// together with a one-cycle done pulse.
//
// Handshake: start is a request that is sampled only while busy=0, which
// includes the done (FIN) cycle. A sampled start captures a, b and sub on that
// same edge. Requests raised while busy=1 are dropped without being queued.
// done is high for exactly one cycle and is never asserted together with busy.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa, opb, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit, carry_nxt, last_bit;

  // The full-add cell and the detection of the final bit position.
  always_comb begin
    sum_bit   = opa[0] ^ opb[0] ^ carry;
    carry_nxt = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    last_bit  = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and status decode. Both outputs come from the state register only.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, serial add/shift, and the result publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c     <= 1'b0;
      v     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          if (start) begin
            // Subtraction is performed as a + ~b + 1. The +1 enters as the initial carry.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          res   <= {sum_bit, res[WIDTH-1:1]};
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            // On the last bit, the carry register holds the carry into the MSB.
            s <= {sum_bit, res[WIDTH-1:1]};
            c <= carry_nxt;
            v <= carry ^ carry_nxt;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
